noc_output_arbiter: RTL and testbench

Per-output-port switch allocator for the NOC router. It shares one output port between NUM_IN input-port buffers (N/S/E/W/local) using round-robin, wormhole-style packet locking. It tracks downstream credits so flits are only sent when the neighbour's receive buffer has space. It drives the mux select, the pop/grant to the winning input buffer, and a registered flit plus send_data strobe toward the link.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/noc_rr_pick.sv | 38 +++
 rtl/noc_output_arbiter.sv | 131 +++++++++++++
 tb/tb_noc_output_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NOC router constants and enums.
// Used by the output arbiter and its round-robin picker.
package noc_pkg;

    localparam int NOC_NUM_IN   = 5;
    localparam int NOC_FLIT_W   = 16;
    localparam int NOC_TAIL_BIT = 15;
    localparam int NOC_CREDITS  = 5;

    typedef enum logic [2:0] {
        PORT_N,
        PORT_S,
        PORT_E,
        PORT_W,
        PORT_L
    } port_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/noc_rr_pick.sv
// Purpose: combinational round-robin picker; the first request after ptr_i wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is used.
module noc_rr_pick
    import noc_pkg::*;
#(
    parameter  int N  = NOC_NUM_IN,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    logic [IW-1:0] p;
    logic          found;

    // Scan from ptr_i+1 around to ptr_i itself, so the last winner is lowest priority.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        found = 1'b0;
        p     = '0;
        for (int k = 1; k <= N; k++) begin
            p = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[p]) begin
                found    = 1'b1;
                gnt_o[p] = 1'b1;
                idx_o    = p;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Purpose: per-output-port switch allocator with round-robin and wormhole packet locking.
// Latency: grant is combinational; the granted flit appears on data_o one cycle later.
// Backpressure: downstream credits gate every grant; no grant while the credit count is zero.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter  int NUM_IN   = NOC_NUM_IN,
    parameter  int FLIT_W   = NOC_FLIT_W,
    parameter  int CREDITS  = NOC_CREDITS,
    parameter  int TAIL_BIT = NOC_TAIL_BIT,
    localparam int IW       = $clog2(NUM_IN),
    localparam int CW       = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        req_i,
    input  logic [NUM_IN*FLIT_W-1:0] data_i,
    output logic [NUM_IN-1:0]        gnt_o,
    input  logic                     inc_credit_i,
    output logic [FLIT_W-1:0]        data_o,
    output logic                     send_data,
    output logic [CW-1:0]            credit_o,
    output logic                     busy_o,
    output logic                     err_o
);

    arb_state_e        state_q, state_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [FLIT_W-1:0] data_q, data_d;
    logic              send_q;
    logic              err_q, err_d;

    logic [NUM_IN-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;

    logic [IW-1:0]     sel_idx;
    logic              sel_vld;
    logic [FLIT_W-1:0] sel_flit;
    logic              send;

    noc_rr_pick #(
        .N (NUM_IN)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // While locked only the packet owner may advance; everyone else waits for the tail.
    always_comb begin
        sel_idx  = pick_idx;
        sel_vld  = pick_vld;
        if (state_q == ARB_LOCKED) begin
            sel_idx = owner_q;
            sel_vld = req_i[owner_q];
        end
        sel_flit = data_i[sel_idx*FLIT_W +: FLIT_W];
        send     = !rst && (credit_q != '0) && sel_vld;
    end

    always_comb begin
        gnt_o = '0;
        if (send) begin
            gnt_o = (state_q == ARB_LOCKED) ? (NUM_IN'(1) << owner_q) : pick_gnt;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        if (send) begin
            data_d = sel_flit;
            if (sel_flit[TAIL_BIT]) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = sel_idx;
            end else begin
                state_d = ARB_LOCKED;
                owner_d = sel_idx;
            end
        end
    end

    // A returned credit only becomes spendable next cycle; inc and send together cancel.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (inc_credit_i && !send) begin
            if (credit_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end else if (!inc_credit_i && send) begin
            credit_d = credit_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            credit_q <= CW'(CREDITS);
            rr_ptr_q <= IW'(NUM_IN - 1);
            owner_q  <= '0;
            data_q   <= '0;
            send_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            send_q   <= send;
            err_q    <= err_d;
        end
    end

    assign data_o    = data_q;
    assign send_data = send_q;
    assign credit_o  = credit_q;
    assign busy_o    = (state_q == ARB_LOCKED);
    assign err_o     = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: queue-fed input buffers, a per-cycle reference model
// of the allocation rules, and hand-computed expectations for each scenario.
module tb_noc_output_arbiter;

    localparam int N  = 5;
    localparam int W  = 16;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic           inc_credit_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic [W-1:0]   data_o;
    logic           send_data;
    logic [CW-1:0]  credit_o;
    logic           busy_o;
    logic           err_o;

    always #5 clk = ~clk;

    noc_output_arbiter #(
        .NUM_IN   (N),
        .FLIT_W   (W),
        .CREDITS  (5),
        .TAIL_BIT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .data_i       (data_i),
        .gnt_o        (gnt_o),
        .inc_credit_i (inc_credit_i),
        .data_o       (data_o),
        .send_data    (send_data),
        .credit_o     (credit_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] q [N][$];
    logic [N-1:0] gnt_snap = '0;
    int           glog [$];
    bit           chk_en = 1'b0;

    int           m_credit = 5;
    int           m_ptr = 4;
    int           m_owner = 0;
    bit           m_locked = 1'b0;
    bit           m_sd = 1'b0;
    bit           m_err = 1'b0;
    logic [W-1:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_i[i]        = (q[i].size() != 0);
            data_i[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic push(input int p, input logic [W-1:0] f);
        q[p].push_back(f);
        drive();
    endtask

    // Advance one cycle: pop whatever was granted, then set the next cycle's inputs.
    task automatic step(input logic inc, input logic r);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_snap[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        inc_credit_i = inc;
        rst          = r;
        drive();
    endtask

    function automatic int sends();
        int n;
        n = 0;
        foreach (glog[k]) if (glog[k] >= 0) n++;
        return n;
    endfunction

    // Reference model: which port must win now, and what the registers must hold next.
    always @(negedge clk) begin : compare
        int           win;
        int           di;
        int           p;
        logic [W-1:0] f;
        win = -1;
        if (!rst && m_credit > 0) begin
            if (m_locked) begin
                if (req_i[m_owner]) win = m_owner;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    p = (m_ptr + k) % N;
                    if (win < 0 && req_i[p]) win = p;
                end
            end
        end
        gnt_snap = gnt_o;
        if (chk_en) begin
            check("gnt", 32'(gnt_o), (win < 0) ? 32'd0 : (32'd1 << win));
            check("send_data", 32'(send_data), 32'(m_sd));
            if (m_sd) check("data_o", 32'(data_o), 32'(m_data));
            check("credit", 32'(credit_o), 32'(m_credit));
            check("busy", 32'(busy_o), 32'(m_locked));
            check("err", 32'(err_o), 32'(m_err));
            check("grant_without_credit", 32'((gnt_o != '0) && (credit_o == '0)), 32'd0);
            di = -1;
            for (int i = 0; i < N; i++) if (gnt_o[i]) di = (di == -1) ? i : -2;
            glog.push_back(di);
        end
        if (rst) begin
            m_credit = 5; m_locked = 1'b0; m_ptr = 4; m_owner = 0;
            m_sd = 1'b0; m_data = '0; m_err = 1'b0;
        end else begin
            m_sd = (win >= 0);
            if (win >= 0) begin
                f      = data_i[win*W +: W];
                m_data = f;
                if (f[15]) begin
                    m_locked = 1'b0;
                    m_ptr    = win;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = win;
                end
            end
            m_credit = m_credit + int'(inc_credit_i) - ((win >= 0) ? 1 : 0);
            if (m_credit > 5) begin
                m_credit = 5;
                m_err    = 1'b1;
            end
        end
    end

    initial begin
        int exp_rr [6];
        exp_rr = '{0, 1, 2, 3, 4, 0};

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk_en = 1'b1;
        #1;
        check("rst_credit", 32'(credit_o), 32'd5);
        check("rst_send_data", 32'(send_data), 32'd0);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0);
            #1;
            check("idle_credit", 32'(credit_o), 32'd5);
            check("idle_send_data", 32'(send_data), 32'd0);
            check("idle_gnt", 32'(gnt_o), 32'd0);
        end

        // Round robin over single-flit packets with credits returned every cycle.
        glog.delete();
        for (int i = 0; i < N; i++) push(i, 16'h8010 + 16'(i));
        push(0, 16'h8020);
        inc_credit_i = 1'b1;
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1;
        check("rr_log_len", 32'(glog.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < glog.size()) check("rr_order", 32'(glog[k]), 32'(exp_rr[k]));
        end
        check("rr_last_data", 32'(data_o), 32'h8020);
        check("rr_last_send", 32'(send_data), 32'd1);
        check("rr_credit", 32'(credit_o), 32'd5);

        // Wormhole lock: port 2 packet holds the port against port 0.
        glog.delete();
        push(2, 16'h0001);
        push(2, 16'h0002);
        push(2, 16'h8003);
        push(0, 16'h8100);
        inc_credit_i = 1'b1;
        step(1'b1, 1'b0);
        #1;
        check("worm_busy", 32'(busy_o), 32'd1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1;
        check("worm_log_len", 32'(glog.size()), 32'd4);
        if (glog.size() >= 4) begin
            check("worm_head", 32'(glog[0]), 32'd2);
            check("worm_body", 32'(glog[1]), 32'd2);
            check("worm_tail", 32'(glog[2]), 32'd2);
            check("worm_next", 32'(glog[3]), 32'd0);
        end
        check("worm_idle", 32'(busy_o), 32'd0);

        // Credit exhaustion: seven single flits, no credit return.
        glog.delete();
        push(1, 16'h8041); push(1, 16'h8042);
        push(2, 16'h8043); push(2, 16'h8044);
        push(3, 16'h8045); push(3, 16'h8046);
        push(4, 16'h8047);
        repeat (8) step(1'b0, 1'b0);
        #1;
        check("exh_sends", 32'(sends()), 32'd5);
        check("exh_credit", 32'(credit_o), 32'd0);
        check("exh_gnt", 32'(gnt_o), 32'd0);

        glog.delete();
        inc_credit_i = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #1;
        check("inc_log_len", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) begin
            check("inc_no_bypass", 32'(glog[0]), 32'hFFFF_FFFF);
            check("inc_one_send", 32'(glog[1]), 32'd2);
        end
        check("inc_data", 32'(data_o), 32'h8044);
        check("inc_credit", 32'(credit_o), 32'd0);

        // Refill to three credits (one pending flit drains along the way).
        inc_credit_i = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1;
        check("refill_credit", 32'(credit_o), 32'd3);

        push(4, 16'h8050);
        inc_credit_i = 1'b1;
        step(1'b0, 1'b0);
        #1;
        check("both_credit", 32'(credit_o), 32'd3);
        check("both_send", 32'(send_data), 32'd1);
        check("both_data", 32'(data_o), 32'h8050);

        inc_credit_i = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1;
        check("ovf_credit", 32'(credit_o), 32'd5);
        check("ovf_err", 32'(err_o), 32'd1);
        repeat (3) step(1'b0, 1'b0);
        #1;
        check("ovf_err_sticky", 32'(err_o), 32'd1);

        // Reset while port 1 holds the lock; port 3 must win right after.
        push(1, 16'h0011);
        push(1, 16'h0012);
        push(1, 16'h8013);
        step(1'b0, 1'b0);
        #1;
        check("mid_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        q[1].delete();
        push(3, 16'h8033);
        step(1'b0, 1'b0);
        #1;
        check("mid_rst_credit", 32'(credit_o), 32'd5);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_send", 32'(send_data), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        check("mid_rst_gnt", 32'(gnt_o), 32'b01000);
        step(1'b0, 1'b0);
        #1;
        check("mid_next_send", 32'(send_data), 32'd1);
        check("mid_next_data", 32'(data_o), 32'h8033);
        repeat (2) step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
